// File: rtl/shift_add_multiplier.sv
// Unsigned shift-and-add multiplier driven by an external step/flag sequencer.
// One iteration per Step; product published with a one-cycle Ready pulse.
module shift_add_multiplier #(
    parameter int WORD_LENGTH    = 16,
    parameter int NBITS_FOR_ITER = $clog2(WORD_LENGTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Step,
    input  logic                       First,
    input  logic                       Last,
    input  logic [WORD_LENGTH-1:0]     Multiplicand,
    input  logic [WORD_LENGTH-1:0]     Multiplier,
    output logic [2*WORD_LENGTH-1:0]   Product,
    output logic                       Ready,
    output logic                       Busy,
    output logic                       Error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_PAD   = 2'd2
    } state_t;

    state_t                      r_state;
    logic [WORD_LENGTH:0]        r_acc;
    logic [WORD_LENGTH-1:0]      r_mul;
    logic [WORD_LENGTH-1:0]      r_mcand;
    logic [NBITS_FOR_ITER-1:0]   r_iter;
    logic [2*WORD_LENGTH-1:0]    r_product;
    logic                        r_ready;
    logic                        r_error;

    logic [WORD_LENGTH-1:0]      w_addend;
    logic [WORD_LENGTH:0]        w_sum;
    logic [2*WORD_LENGTH:0]      w_shift;
    logic [NBITS_FOR_ITER-1:0]   w_iter_next;
    logic                        w_iter_done;

    // One shift-add iteration: conditional add, then shift {acc,mul} right.
    always_comb begin
        w_addend    = r_mul[0] ? r_mcand : '0;
        w_sum       = r_acc + {1'b0, w_addend};
        w_shift     = {w_sum, r_mul} >> 1;
        w_iter_next = r_iter + NBITS_FOR_ITER'(1);
        w_iter_done = (w_iter_next == NBITS_FOR_ITER'(WORD_LENGTH));
    end

    // Sequencer-qualified FSM and datapath; First always wins and reloads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mul     <= '0;
            r_mcand   <= '0;
            r_iter    <= '0;
            r_product <= '0;
            r_ready   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (Step) begin
                if (First) begin
                    r_mcand <= Multiplicand;
                    r_mul   <= Multiplier;
                    r_acc   <= '0;
                    r_iter  <= '0;
                    r_error <= 1'b0;
                    r_state <= S_ACCUM;
                end else begin
                    case (r_state)
                        S_ACCUM: begin
                            if (Last) begin
                                r_error <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                {r_acc, r_mul} <= w_shift;
                                r_iter         <= w_iter_next;
                                if (w_iter_done) begin
                                    r_state <= S_PAD;
                                end
                            end
                        end
                        S_PAD: begin
                            if (Last) begin
                                r_product <= {r_acc[WORD_LENGTH-1:0], r_mul};
                                r_ready   <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign Product = r_product;
    assign Ready   = r_ready;
    assign Busy    = (r_state != S_IDLE);
    assign Error   = r_error;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Reference results come from plain integer multiplication.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        Step;
    logic        First;
    logic        Last;
    logic [15:0] Multiplicand;
    logic [15:0] Multiplier;
    logic [31:0] Product;
    logic        Ready;
    logic        Busy;
    logic        Error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_prod;

    shift_add_multiplier #(.WORD_LENGTH(16)) dut (
        .clk(clk), .reset(reset), .Step(Step), .First(First), .Last(Last),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Product(Product), .Ready(Ready), .Busy(Busy), .Error(Error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        return {16'b0, a} * {16'b0, b};
    endfunction

    // Random idle gap (Step=0) before each step to exercise the hold rule.
    task automatic step(input logic f, input logic l);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        Step = 1'b1; First = f; Last = l;
        @(negedge clk);
        Step = 1'b0; First = 1'b0; Last = 1'b0;
        Multiplicand = 16'($urandom);
        Multiplier   = 16'($urandom);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        Multiplicand = a; Multiplier = b;
        Step = 1'b1; First = 1'b1; Last = 1'b0;
        @(negedge clk);
        Step = 1'b0; First = 1'b0;
        Multiplicand = 16'($urandom);
        Multiplier   = 16'($urandom);
    endtask

    task automatic iters(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int npad);
        load(a, b);
        iters(16);
        iters(npad);
        step(1'b0, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        Step = 1'b1; First = 1'b1; Last = 1'b0;
        Multiplicand = 16'hFFFF; Multiplier = 16'hFFFF;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        Step = 1'b0; First = 1'b0;
        reset = 1'b1;
        n_checks++;
        if (Product !== 32'h0) begin
            n_fail++; $display("FAIL reset_product: got %h want 0", Product);
        end
        n_checks++;
        if ({Ready, Busy, Error} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got RBE=%b want 000", {Ready, Busy, Error});
        end
    endtask

    task automatic test_basic();
        load(16'd3, 16'd5);
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy: got %b want 1", Busy);
        end
        iters(16 + 18);
        step(1'b0, 1'b1);
        n_checks++;
        if (Product !== 32'h0000000F) begin
            n_fail++; $display("FAIL basic_product: got %h want 0000000f", Product);
        end
        n_checks++;
        if (Ready !== 1'b1 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_ready: got R=%b B=%b want R=1 B=0", Ready, Busy);
        end
        @(negedge clk);
        n_checks++;
        if (Ready !== 1'b0 || Product !== 32'h0000000F) begin
            n_fail++; $display("FAIL basic_pulse: got R=%b P=%h want R=0 P=f", Ready, Product);
        end
    endtask

    task automatic test_corner();
        run_op(16'hFFFF, 16'hFFFF, 18);
        n_checks++;
        if (Product !== 32'hFFFE0001 || Ready !== 1'b1) begin
            n_fail++; $display("FAIL corner_max: got P=%h R=%b want fffe0001 R=1", Product, Ready);
        end
        run_op(16'h0000, 16'h1234, 18);
        n_checks++;
        if (Product !== 32'h0 || Ready !== 1'b1) begin
            n_fail++; $display("FAIL corner_zero: got P=%h R=%b want 0 R=1", Product, Ready);
        end
    endtask

    task automatic test_restart();
        load(16'd2, 16'd2);
        iters(5);
        run_op(16'd6, 16'd7, 18);
        n_checks++;
        if (Product !== 32'h2A || Error !== 1'b0 || Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got P=%h E=%b R=%b want 2a E=0 R=1", Product, Error, Ready);
        end
    endtask

    task automatic test_early_last();
        load(16'd7, 16'd9);
        iters(10);
        step(1'b0, 1'b1);
        n_checks++;
        if (Error !== 1'b1 || Ready !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_flags: got E=%b R=%b B=%b want E=1 R=0 B=0", Error, Ready, Busy);
        end
        n_checks++;
        if (Product !== 32'h2A) begin
            n_fail++; $display("FAIL early_product: got %h want 2a", Product);
        end
        iters(3);
        n_checks++;
        if (Error !== 1'b1 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL early_sticky: got E=%b B=%b want E=1 B=0", Error, Busy);
        end
        load(16'd1, 16'd1);
        n_checks++;
        if (Error !== 1'b0) begin
            n_fail++; $display("FAIL early_clear: got %b want 0", Error);
        end
        iters(16);
        step(1'b0, 1'b1);
        n_checks++;
        if (Product !== 32'h1 || Ready !== 1'b1) begin
            n_fail++; $display("FAIL early_recover: got P=%h R=%b want 1 R=1", Product, Ready);
        end
    endtask

    task automatic test_idle();
        step(1'b0, 1'b1);
        n_checks++;
        if ({Ready, Busy, Error} !== 3'b000 || Product !== 32'h1) begin
            n_fail++;
            $display("FAIL idle_last: got RBE=%b P=%h want 000 P=1", {Ready, Busy, Error}, Product);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if ({Ready, Busy, Error} !== 3'b000 || Product !== 32'h1) begin
            n_fail++;
            $display("FAIL idle_step: got RBE=%b P=%h want 000 P=1", {Ready, Busy, Error}, Product);
        end
    endtask

    task automatic test_reset_mid();
        load(16'($urandom), 16'($urandom));
        iters(8);
        pulse_reset();
        n_checks++;
        if (Product !== 32'h0 || Busy !== 1'b0 || Error !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid: got P=%h B=%b E=%b want 0 0 0", Product, Busy, Error);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (Product !== 32'h0 || Ready !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_last: got P=%h R=%b B=%b want 0 0 0", Product, Ready, Busy);
        end
    endtask

    // Step held high every cycle: load, 16 iterations, 2 pads, Last.
    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom) | 16'h8001;
        b = 16'($urandom) | 16'h8001;
        @(negedge clk);
        Multiplicand = a; Multiplier = b;
        Step = 1'b1; First = 1'b1; Last = 1'b0;
        @(negedge clk);
        First = 1'b0;
        Multiplicand = ~a; Multiplier = ~b;
        repeat (18) @(negedge clk);
        Last = 1'b1;
        @(negedge clk);
        Step = 1'b0; Last = 1'b0;
        exp_prod = mul_ref(a, b);
        n_checks++;
        if (Product !== exp_prod || Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b: got P=%h R=%b want %h R=1", Product, Ready, exp_prod);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        int kind;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                load(a, b);
                iters($urandom_range(0, 15));
                step(1'b0, 1'b1);
                n_checks++;
                if (Product !== exp_prod || Error !== 1'b1 || Ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_early[%0d]: got P=%h E=%b R=%b want %h E=1 R=0",
                             i, Product, Error, Ready, exp_prod);
                end
            end else begin
                if (kind == 2) begin
                    load(16'($urandom), 16'($urandom));
                    iters($urandom_range(0, 20));
                end
                run_op(a, b, $urandom_range(0, 20));
                exp_prod = mul_ref(a, b);
                n_checks++;
                if (Product !== exp_prod || Error !== 1'b0 || Ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_op[%0d]: got P=%h E=%b R=%b want %h E=0 R=1",
                             i, Product, Error, Ready, exp_prod);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; Step = 1'b0; First = 1'b0; Last = 1'b0;
        Multiplicand = '0; Multiplier = '0;
        exp_prod = '0;
        test_reset();
        test_basic();
        test_corner();
        test_restart();
        test_early_last();
        test_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
